uart_reg_target: RTL
====================

// Module: uart_reg_target
// PURPOSE
//  Bus responder (target) for the uart_transaction bridge: decodes MCmd/MAddr/MData,
//  handshakes with SCmdAccept, returns read data on SData/SResp. Holds an 8-bit
//  register bank driving prototype control logic. Writes are posted (no SResp);
//  each read returns exactly one one-cycle response.
// PARAMETERS
//  NUM_REGS     16     register count (2..256); reg 0 is read-only ID
//  ID_VALUE     8'hA5  value returned when reading reg 0
//  ACCEPT_WAIT  0      extra wait cycles before SCmdAccept (0..15)
//  READ_LAT     1      cycles from SCmdAccept to SResp (1..15)
// PORTS
//  clk            in   1             clock
//  reset_n        in   1             async active-low reset
//  MCmd           in   3             000 idle, 001 write, 010 read; held until accepted
//  MAddr          in   8             register address
//  MData          in   8             write data
//  SCmdAccept     out  1             one-cycle command accept pulse
//  SData          out  8             read data, valid only while SResp!=00
//  SResp          out  2             00 none, 01 DVA, 11 ERR
//  reg_q          out  8*NUM_REGS    flat register contents, reg n at [8n+7:8n]
//  reg_wr_pulse   out  1             one-cycle strobe on committed write
//  reg_wr_addr    out  8             address of last committed write
// BEHAVIOUR
//  Reset: single async clear of all state to the values below; no other state is touched.
//  - FSM -> IDLE. SCmdAccept=0, SResp=00, SData=00, reg_wr_pulse=0, reg_wr_addr=00.
//  - All regs 1..NUM_REGS-1 = 00. Any pending accept/response is discarded.
//  FSM states:
//  - IDLE: on MCmd!=000 latch cmd/addr/data, load wait ctr=ACCEPT_WAIT -> WAIT.
//  - WAIT: ctr==0 -> ACCEPT, else decrement.
//  - ACCEPT: SCmdAccept=1 this cycle only.
//    write: commit at end of cycle, -> IDLE.
//    read: capture data, load lat ctr=READ_LAT-1 -> RLAT.
//    other nonzero cmd: accept and discard, -> IDLE.
//  - RLAT: ctr==0 -> RESP, else decrement.
//  - RESP: drive SResp/SData for one cycle, then -> IDLE.
//  Timing: MCmd first nonzero in cycle k ->
//  - SCmdAccept high in cycle k+1+ACCEPT_WAIT.
//  - Write: reg and reg_wr_pulse update in cycle k+2+ACCEPT_WAIT.
//  - Read: SResp=01 in cycle k+1+ACCEPT_WAIT+READ_LAT.
//  Initiator drops MCmd the cycle after accept; IDLE never re-samples an accepted command.
//  No new command accepted while in RLAT/RESP (one outstanding read max).
//  Read data is captured at accept, so later writes do not alter it.
//  Address decode:
//  - Write to reg 0: accepted, no reg change, no reg_wr_pulse.
//  - Read reg 0 returns ID_VALUE.
//  - Back-to-back write then read of same addr returns the new value.
//  - Addr >= NUM_REGS: behaviour set by macro below.
// CONFIGURATION
//  UART_REG_TARGET_ADDR_ERR_EN defined:
//  - read of addr >= NUM_REGS -> SResp=11, SData=8'h00 (bridge reports 0xED).
//  - write to addr >= NUM_REGS -> accepted and dropped, no reg_wr_pulse.
//  Not defined: address uses MAddr modulo NUM_REGS (NUM_REGS power of 2); SResp never 11.
// TESTING
//  1 Reset: reset_n low mid-RLAT -> SResp stays 00, no response after release, reg_q all 00.
//  2 Write MAddr=03 MData=5C (W=0) -> SCmdAccept k+1, reg_wr_pulse k+2, reg_q[31:24]=5C, SResp 00.
//  3 Read MAddr=03 (W=2, L=3) -> SCmdAccept k+3, SResp=01 SData=5C in k+6, one cycle only.
//  4 Read reg 0 -> SData=A5; write 0x77 to reg 0 then read -> still A5, no wr pulse.
//  5 Read 0x20 (NUM_REGS=16): with _EN -> SResp=11 SData=00; without -> returns reg 0 (A5).
//  6 Read, then MCmd=001 during RLAT -> accept withheld until cycle after SResp.

Source files
------------

// File: rtl/uart_reg_target.sv
// uart_reg_target: bus target for the uart_transaction bridge.
// Decodes MCmd/MAddr/MData, handshakes with a one-cycle SCmdAccept, and
// returns read data on SData/SResp after READ_LAT cycles. Holds an 8-bit
// register bank (reg 0 is a read-only ID). Writes are posted (no SResp).
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   MCmd[2:0]      000 idle, 001 write, 010 read (held until accepted)
//   MAddr[7:0]     register address
//   MData[7:0]     write data
//   SCmdAccept     one-cycle accept pulse
//   SData[7:0]     read data, non-zero only while SResp != 00
//   SResp[1:0]     00 none, 01 DVA, 11 ERR
//   reg_q          flat register contents, reg n at [8n+7:8n] (reg 0 slot reads 00)
//   reg_wr_pulse   one-cycle strobe on a committed write
//   reg_wr_addr    register index of the last committed write
//
// Build option: UART_REG_TARGET_ADDR_ERR_EN
//   defined     - reads of MAddr >= NUM_REGS return SResp=11/SData=00,
//                 writes there are accepted and dropped.
//   not defined - MAddr is taken modulo NUM_REGS (NUM_REGS a power of 2).
module uart_reg_target #(
   parameter int unsigned NUM_REGS    = 16,
   parameter logic [7:0]  ID_VALUE    = 8'hA5,
   parameter int unsigned ACCEPT_WAIT = 0,
   parameter int unsigned READ_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            MCmd,
   input  logic [7:0]            MAddr,
   input  logic [7:0]            MData,
   output logic                  SCmdAccept,
   output logic [7:0]            SData,
   output logic [1:0]            SResp,
   output logic [8*NUM_REGS-1:0] reg_q,
   output logic                  reg_wr_pulse,
   output logic [7:0]            reg_wr_addr
);

   localparam int unsigned CW   = 4;
   localparam int unsigned IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [2:0] CMD_IDLE = 3'b000;
   localparam logic [2:0] CMD_WR   = 3'b001;
   localparam logic [2:0] CMD_RD   = 3'b010;

   localparam logic [1:0] RESP_NONE = 2'b00;
   localparam logic [1:0] RESP_DVA  = 2'b01;
   localparam logic [1:0] RESP_ERR  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_ACCEPT = 3'd2,
      ST_RLAT   = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   state_t          state, state_d;
   logic [CW-1:0]   ctr, ctr_d;
   logic [2:0]      cmd_q, cmd_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      data_q, data_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            rerr_q, rerr_d;

   logic            accept_d;
   logic [1:0]      sresp_d;
   logic [7:0]      sdata_d;
   logic            wr_pulse_d;
   logic [7:0]      wr_addr_d;

   logic [IDXW-1:0] idx_c;
   logic            in_range_c;
   logic            wr_en_c;
   logic [7:0]      rd_val_c;

   // Storage for regs 1..NUM_REGS-1; reg 0 has no storage (ID only).
   logic [NUM_REGS-1:1][7:0] bank_q;

   // Address decode and read mux on the latched command.
   always_comb begin
      idx_c = addr_q[IDXW-1:0];
`ifdef UART_REG_TARGET_ADDR_ERR_EN
      in_range_c = (32'(addr_q) < NUM_REGS);
`else
      in_range_c = 1'b1;
`endif
      rd_val_c = (idx_c == '0) ? ID_VALUE : bank_q[idx_c];
   end

`ifndef UART_REG_TARGET_ADDR_ERR_EN
   // Upper address bits alias onto the bank when out-of-range checking is off.
   logic unused_addr;
   assign unused_addr = ^addr_q;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state;
      ctr_d      = ctr;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      data_d     = data_q;
      rdata_d    = rdata_q;
      rerr_d     = rerr_q;
      wr_en_c    = 1'b0;
      wr_addr_d  = reg_wr_addr;
      accept_d   = 1'b0;
      wr_pulse_d = 1'b0;
      sresp_d    = RESP_NONE;
      sdata_d    = 8'h00;

      case (state)
         ST_IDLE: begin
            if (MCmd != CMD_IDLE) begin
               cmd_d  = MCmd;
               addr_d = MAddr;
               data_d = MData;
               // ctr counts the WAIT cycles remaining after the current one.
               if (ACCEPT_WAIT == 0) begin
                  state_d = ST_ACCEPT;
               end else begin
                  ctr_d   = CW'(ACCEPT_WAIT - 1);
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (ctr == '0) state_d = ST_ACCEPT;
            else           ctr_d   = ctr - CW'(1);
         end
         ST_ACCEPT: begin
            state_d = ST_IDLE;
            if (cmd_q == CMD_WR) begin
               wr_en_c = in_range_c && (idx_c != '0);
               if (wr_en_c) wr_addr_d = 8'(idx_c);
            end else if (cmd_q == CMD_RD) begin
               // Capture now so later writes cannot change the returned value.
               rerr_d  = !in_range_c;
               rdata_d = in_range_c ? rd_val_c : 8'h00;
               if (READ_LAT <= 1) begin
                  state_d = ST_RESP;
               end else begin
                  ctr_d   = CW'(READ_LAT - 2);
                  state_d = ST_RLAT;
               end
            end
         end
         ST_RLAT: begin
            if (ctr == '0) state_d = ST_RESP;
            else           ctr_d   = ctr - CW'(1);
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered, so they are derived from the next state.
      accept_d   = (state_d == ST_ACCEPT);
      wr_pulse_d = wr_en_c;
      if (state_d == ST_RESP) begin
         sresp_d = rerr_d ? RESP_ERR : RESP_DVA;
         sdata_d = rdata_d;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         ctr          <= '0;
         cmd_q        <= CMD_IDLE;
         addr_q       <= 8'h00;
         data_q       <= 8'h00;
         rdata_q      <= 8'h00;
         rerr_q       <= 1'b0;
         SCmdAccept   <= 1'b0;
         SResp        <= RESP_NONE;
         SData        <= 8'h00;
         reg_wr_pulse <= 1'b0;
         reg_wr_addr  <= 8'h00;
      end else begin
         state        <= state_d;
         ctr          <= ctr_d;
         cmd_q        <= cmd_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         rdata_q      <= rdata_d;
         rerr_q       <= rerr_d;
         SCmdAccept   <= accept_d;
         SResp        <= sresp_d;
         SData        <= sdata_d;
         reg_wr_pulse <= wr_pulse_d;
         reg_wr_addr  <= wr_addr_d;
      end
   end

   // Register bank: write commits at the end of the accept cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bank_q <= '0;
      end else if (wr_en_c) begin
         bank_q[idx_c] <= data_q;
      end
   end

   assign reg_q = {bank_q, 8'h00};

endmodule
